// File: rtl/p_emap_scatter_8.sv
// Scatter unit: writes a batch of 8 indexed elements into a banked vector memory
// using per-element word read-modify-write, with an independent registered read port.
module p_emap_scatter_8 #(
    parameter int no_of_elements_in_input = 8,
    parameter int element_width           = 32,
    parameter int no_of_units             = 8,
    parameter int mem_depth               = 1024
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [no_of_elements_in_input*32-1:0]     row_nos,
    input  logic [no_of_elements_in_input*element_width-1:0] input_row,
    input  logic [31:0]                               no_of_multiples,
    output logic                                      batch_done,
    output logic                                      all_done,
    input  logic                                      rd_en,
    input  logic [31:0]                               rd_addr,
    output logic [no_of_units*element_width-1:0]      rd_data
);

    localparam int LANE_BITS = $clog2(no_of_units);
    localparam int ADDR_W    = $clog2(mem_depth);
    localparam int K_BITS    = $clog2(no_of_elements_in_input);
    localparam int WORD_W    = no_of_units * element_width;
    localparam logic [K_BITS-1:0] K_LAST = K_BITS'(no_of_elements_in_input - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    // Handshake: a batch transfers on a clk edge where in_valid && in_ready;
    // the source holds row_nos/input_row stable until that edge.
    state_t                   state_q, next_state;
    logic [WORD_W-1:0]        mem [mem_depth];
    logic [31:0]              idx_q [no_of_elements_in_input];
    logic [element_width-1:0] val_q [no_of_elements_in_input];
    logic [K_BITS-1:0]        k_q;
    logic [WORD_W-1:0]        hold_q;
    logic [WORD_W-1:0]        merged;
    logic [31:0]              batch_cnt_q;
    logic [31:0]              mult_q;
    logic [31:0]              run_target;
    logic [31:0]              cur_idx;
    logic [31:0]              cur_word;
    logic [LANE_BITS-1:0]     cur_lane;
    logic [ADDR_W-1:0]        wr_addr;
    logic                     cur_skip;
    logic                     accept;
    logic                     k_step;
    logic                     wr_en;

    assign accept     = in_valid && in_ready;
    assign cur_idx    = idx_q[k_q];
    assign cur_word   = cur_idx >> LANE_BITS;
    assign cur_lane   = cur_idx[LANE_BITS-1:0];
    assign wr_addr    = cur_word[ADDR_W-1:0];
    assign cur_skip   = (cur_idx == 32'hFFFF_FFFF) || (cur_word >= 32'(mem_depth));
    assign run_target = (mult_q == 32'd0) ? 32'd1 : mult_q;
    assign wr_en      = (state_q == WR) && !reset;

    // Lane 0 is the most significant slice of the word.
    always_comb begin
        merged = hold_q;
        for (int r = 0; r < no_of_units; r++) begin
            if (cur_lane == LANE_BITS'(r))
                merged[(no_of_units-r)*element_width-1 -: element_width] = val_q[k_q];
        end
    end

    always_comb begin
        next_state = state_q;
        k_step     = 1'b0;
        case (state_q)
            IDLE: if (accept) next_state = RD;
            RD: begin
                if (cur_skip) begin
                    k_step     = 1'b1;
                    next_state = (k_q == '0) ? DONE : RD;
                end else begin
                    next_state = WR;
                end
            end
            WR: begin
                k_step     = 1'b1;
                next_state = (k_q == '0) ? DONE : RD;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= K_LAST;
            in_ready    <= 1'b1;
            batch_done  <= 1'b0;
            all_done    <= 1'b0;
            batch_cnt_q <= 32'd0;
            mult_q      <= 32'd0;
        end else begin
            state_q    <= next_state;
            batch_done <= 1'b0;
            all_done   <= 1'b0;
            if (accept) begin
                for (int e = 0; e < no_of_elements_in_input; e++) begin
                    idx_q[e] <= row_nos[e*32 +: 32];
                    val_q[e] <= input_row[e*element_width +: element_width];
                end
                k_q      <= K_LAST;
                in_ready <= 1'b0;
                if (batch_cnt_q == 32'd0)
                    mult_q <= no_of_multiples;
            end
            if (k_step && (k_q != '0))
                k_q <= k_q - 1'b1;
            if ((state_q == RD) && !cur_skip)
                hold_q <= mem[wr_addr];
            if (state_q == DONE) begin
                batch_done <= 1'b1;
                if (batch_cnt_q + 32'd1 == run_target) begin
                    all_done    <= 1'b1;
                    batch_cnt_q <= 32'd0;
                end else begin
                    batch_cnt_q <= batch_cnt_q + 32'd1;
                end
            end
            // The source sees in_ready one cycle after the batch_done pulse.
            if (batch_done)
                in_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= merged;
    end

    // Non-blocking read of mem gives old data on a same-edge write.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= (rd_addr < 32'(mem_depth)) ? mem[rd_addr[ADDR_W-1:0]] : '0;
    end

endmodule

// File: tb/tb_p_emap_scatter_8.sv
// Bench for p_emap_scatter_8: directed scenarios plus random batches checked
// against an element-addressed memory model and a batch-run counter model.
module tb_p_emap_scatter_8;

    localparam int NE    = 8;
    localparam int EW    = 32;
    localparam int NU    = 8;
    localparam int DEPTH = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [NE*32-1:0] row_nos;
    logic [NE*EW-1:0] input_row;
    logic [31:0]      no_of_multiples;
    logic             batch_done;
    logic             all_done;
    logic             rd_en;
    logic [31:0]      rd_addr;
    logic [NU*EW-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] elem [DEPTH*NU];
    logic [31:0] bi [NE];
    logic [31:0] bv [NE];
    int          run_cnt = 0;
    int          run_tgt = 1;

    p_emap_scatter_8 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .row_nos(row_nos), .input_row(input_row), .no_of_multiples(no_of_multiples),
        .batch_done(batch_done), .all_done(all_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_skip(input logic [31:0] idx);
        return (idx == 32'hFFFF_FFFF) || (idx >= 32'(DEPTH * NU));
    endfunction

    function automatic logic [255:0] model_word(input logic [31:0] a);
        logic [255:0] w;
        w = '0;
        if (a < 32'(DEPTH))
            for (int r = 0; r < NU; r++) w[(NU-r)*EW-1 -: EW] = elem[int'(a)*NU + r];
        return w;
    endfunction

    // Elements land in order 7..0, so the lowest slice of duplicates survives.
    function automatic int model_apply(input int upto);
        int lat;
        lat = 1;
        for (int k = NE-1; k >= upto; k--) begin
            if (is_skip(bi[k])) lat += 1;
            else begin
                elem[int'(bi[k])] = bv[k];
                lat += 2;
            end
        end
        return lat;
    endfunction

    task automatic drive_batch(input logic [31:0] mult);
        for (int k = 0; k < NE; k++) begin
            row_nos[k*32 +: 32]  = bi[k];
            input_row[k*EW +: EW] = bv[k];
        end
        no_of_multiples = mult;
        in_valid = 1'b1;
    endtask

    task automatic run_batch(input logic [31:0] mult);
        int lat;
        int n;
        bit exp_all;
        lat = model_apply(0);
        if (run_cnt == 0) run_tgt = (mult == 0) ? 1 : int'(mult);
        run_cnt++;
        exp_all = (run_cnt == run_tgt);
        if (exp_all) run_cnt = 0;
        @(negedge clk);
        check("ready_before", 256'(in_ready), 256'(1));
        drive_batch(mult);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_busy", 256'(in_ready), 256'(0));
        n = 0;
        while (!batch_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency", 256'(n), 256'(lat));
        check("all_done", 256'(all_done), 256'(exp_all));
        check("ready_at_done", 256'(in_ready), 256'(0));
        @(negedge clk);
        check("done_pulse", 256'(batch_done), 256'(0));
        check("ready_after", 256'(in_ready), 256'(1));
    endtask

    task automatic read_check(input logic [31:0] a, input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check(tag, rd_data, model_word(a));
    endtask

    initial begin
        int n;
        int pulses;
        logic [255:0] old_w;
        for (int i = 0; i < DEPTH*NU; i++) elem[i] = 32'd0;
        reset = 1'b1; in_valid = 1'b0; row_nos = '0; input_row = '0;
        no_of_multiples = 32'd1; rd_en = 1'b0; rd_addr = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 256'(in_ready), 256'(1));
        check("rst_batch_done", 256'(batch_done), 256'(0));
        check("rst_all_done", 256'(all_done), 256'(0));
        check("rst_rd_data", rd_data, 256'(0));

        // Sequential indices into word 0
        for (int k = 0; k < NE; k++) begin bi[k] = k; bv[k] = 32'h10 + k; end
        run_batch(32'd1);
        read_check(32'd0, "seq_word0");
        check("seq_word0_const", rd_data,
              256'h00000010_00000011_00000012_00000013_00000014_00000015_00000016_00000017);

        // Mixed valid / skipped indices
        bi[0] = 3; bi[1] = 11; bi[2] = 32'hFFFF_FFFF; bi[3] = 9999999;
        bi[4] = 4; bi[5] = 12; bi[6] = 32'hFFFF_FFFF; bi[7] = 5;
        for (int k = 0; k < NE; k++) bv[k] = $urandom;
        run_batch(32'd1);
        read_check(32'd0, "mix_word0");
        read_check(32'd1, "mix_word1");

        // All slices hit index 6
        for (int k = 0; k < NE; k++) begin bi[k] = 6; bv[k] = 32'hA0 + k; end
        run_batch(32'd1);
        read_check(32'd0, "dup_word0");

        // Run of three batches, then a fourth starts a new run
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < NE; k++) begin bi[k] = 8 + $urandom_range(0, 15); bv[k] = $urandom; end
            run_batch((b == 3) ? 32'd5 : 32'd3);
        end
        read_check(32'd1, "run_word1");
        read_check(32'd2, "run_word2");

        // Reset in the 5th cycle after accept
        for (int k = 0; k < NE; k++) begin bi[k] = 24 + k; bv[k] = $urandom; end
        @(negedge clk);
        drive_batch(32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = model_apply(6);
        run_cnt = 0;
        check("abort_ready", 256'(in_ready), 256'(1));
        check("abort_rd_data", rd_data, 256'(0));
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (batch_done) pulses++;
        end
        check("abort_no_done", 256'(pulses), 256'(0));
        read_check(32'd3, "abort_word3");

        // Read colliding with the write of a single valid element
        for (int k = 0; k < NE; k++) begin bi[k] = 32'hFFFF_FFFF; bv[k] = $urandom; end
        bi[7] = 42;
        old_w = model_word(32'd5);
        @(negedge clk);
        drive_batch(32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = 32'd5;
        @(negedge clk);
        check("coll_old", rd_data, old_w);
        n = model_apply(0);
        @(negedge clk);
        rd_en = 1'b0;
        check("coll_new", rd_data, model_word(32'd5));
        n = 3;
        while (!batch_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("coll_latency", 256'(n), 256'(10));
        check("coll_all_done", 256'(all_done), 256'(1));

        // Random batches with collisions, skips and the top word
        for (int b = 0; b < 24; b++) begin
            for (int k = 0; k < NE; k++) begin
                case ($urandom_range(0, 9))
                    0: bi[k] = 32'hFFFF_FFFF;
                    1: bi[k] = 32'(DEPTH*NU) + $urandom_range(0, 1000);
                    2: bi[k] = 32'(DEPTH*NU - NU) + $urandom_range(0, 7);
                    default: bi[k] = $urandom_range(0, 71);
                endcase
                bv[k] = $urandom;
            end
            run_batch($urandom_range(0, 3));
        end
        for (int a = 0; a < 9; a++) read_check(a, "rand_word");
        read_check(32'd1023, "rand_top_word");
        read_check(32'd2000, "oob_read");
        read_check(32'hFFFF_FFFF, "oob_read_max");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
